input_debouncer: RTL
====================

Name: input_debouncer

Overview:
Sits directly downstream of the input synchronizer on each external button/switch line of the 4-bit CPU. Filters contact bounce on the already-synchronized signal with a per-line confirmation FSM and counter. Produces a clean debounced level plus single-cycle rising/falling edge pulses for the control logic (step, run, load).

Parameters:
DEBOUNCE_CYCLES, 4, consecutive enabled samples of a new level required before output_o changes; legal range 2..65535
COUNTER_WIDTH, $clog2(DEBOUNCE_CYCLES+1), width of the internal confirmation counter; derived, not overridden

Ports:
clk_i  input  1  system clock; all state updates on rising edge
reset_i  input  1  asynchronous, active-high reset
input_i  input  1  synchronized raw level from the upstream synchronizer
sample_en_i  input  1  sampling strobe (prescaler tick); tie to 1 to sample every cycle
output_o  output  1  debounced level
rise_o  output  1  one-clock pulse when output_o goes 0->1
fall_o  output  1  one-clock pulse when output_o goes 1->0

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-high on reset_i. While reset_i=1: state=LOW_STABLE, count=0, output_o=0, rise_o=0, fall_o=0, independent of clk_i or input_i.
- All outputs are registered; no combinational path from input_i to any output.
- States: LOW_STABLE, RISE_CHECK, HIGH_STABLE, FALL_CHECK.
- Cycles with sample_en_i=0: state, count and output_o hold; rise_o=fall_o=0.
- Enabled cycles (sample_en_i=1):
  - LOW_STABLE: input_i=1 -> RISE_CHECK, count=1. Otherwise stay, count=0.
  - RISE_CHECK: input_i=0 -> LOW_STABLE, count=0, no pulse (glitch rejected). input_i=1 and count<DEBOUNCE_CYCLES-1 -> count+1. input_i=1 and count=DEBOUNCE_CYCLES-1 -> HIGH_STABLE, count=0, output_o=1, rise_o=1 for that clock only.
  - HIGH_STABLE / FALL_CHECK: mirror image with input_i inverted. Confirmation -> LOW_STABLE, output_o=0, fall_o=1 for one clock.
- Latency: with sample_en_i=1, output_o changes on the DEBOUNCE_CYCLES-th rising edge that samples the new level. The first such edge is counted as 1.
- rise_o/fall_o:
  - Asserted on the same edge on which output_o changes; deasserted on the next edge regardless of sample_en_i.
  - Never both high.
  - Never high in consecutive cycles, because the minimum time between opposite edges is DEBOUNCE_CYCLES samples.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. In stable states it is held at 0.
- Input already high at reset release: treated as a new level. rise_o fires after DEBOUNCE_CYCLES samples; no spurious fall_o.
- Reset asserted mid-CHECK: the check is aborted, count cleared, no pulse emitted.

Decomposition:
- Shared include file holds the 2-bit state encodings: LOW_STABLE=2'b00, RISE_CHECK=2'b01, HIGH_STABLE=2'b11, FALL_CHECK=2'b10. The CPU top-level debug/state probes use the same file.
- No sub-module. The counter and FSM are small enough to live inline.
- Top level instantiates one input_debouncer per button line, directly after its synchronizer.

Test Plan:
DEBOUNCE_CYCLES=4, 10 ns clock, sample_en_i=1 unless stated.
- Reset: reset_i=1 while input_i=1 and clock runs -> output_o=0, rise_o=0, fall_o=0 throughout. After release, rise_o pulses exactly on the 4th edge.
- Clean rise: input_i 0->1 held 10 cycles -> output_o=1 from the 4th sampling edge onward. rise_o high for exactly one cycle, coincident with that edge. fall_o stays 0.
- Bounce: input_i high 3 cycles, low 1, high 2, low -> output_o stays 0, no pulses. Counter visibly returns to 0 after each low.
- Fall plus glitch: from HIGH_STABLE, input_i low 2 cycles, high 1, then low 5 -> first dip ignored. output_o=0 and fall_o one-cycle pulse on the 4th consecutive low sample.
- Strobed sampling: sample_en_i=1 every 4th cycle, input_i held high -> output_o rises on the 4th enabled edge (about 16 clocks). A 3-cycle low glitch between strobes is not seen and is ignored.
- Async reset mid-check: reset_i asserted for 3 ns between edges while in RISE_CHECK with count=2 -> output_o=0, state LOW_STABLE immediately. After release with input_i still high, a full 4 samples are required before rise_o.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the button/switch debouncer: FSM state encodings
// that the CPU debug/state probes also decode.
package input_debouncer_pkg;

   typedef enum logic [1:0] {
      LOW_STABLE  = 2'b00,
      RISE_CHECK  = 2'b01,
      HIGH_STABLE = 2'b11,
      FALL_CHECK  = 2'b10
   } deb_state_t;

   function automatic logic is_stable(input deb_state_t s);
      return (s == LOW_STABLE) || (s == HIGH_STABLE);
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// Per-line contact-bounce filter: a new level must be seen on DEBOUNCE_CYCLES
// consecutive enabled samples before the registered output follows it.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic input_i,
   input  logic sample_en_i,
   output logic output_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int COUNTER_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [COUNTER_WIDTH-1:0] ONE_CNT  = COUNTER_WIDTH'(1);

   deb_state_t                r_state;
   logic [COUNTER_WIDTH-1:0]  r_count;
   logic                      r_out;
   logic                      r_rise;
   logic                      r_fall;

   deb_state_t                w_state_nxt;
   logic [COUNTER_WIDTH-1:0]  w_count_nxt;
   logic                      w_out_nxt;
   logic                      w_rise_nxt;
   logic                      w_fall_nxt;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= LOW_STABLE;
         r_count <= '0;
         r_out   <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_out   <= w_out_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   // Pulses default low so they last exactly one clock even when the strobe drops.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_out_nxt   = r_out;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      if (sample_en_i) begin
         case (r_state)
            LOW_STABLE: begin
               if (input_i) begin
                  w_state_nxt = RISE_CHECK;
                  w_count_nxt = ONE_CNT;
               end else begin
                  w_count_nxt = '0;
               end
            end
            RISE_CHECK: begin
               if (!input_i) begin
                  w_state_nxt = LOW_STABLE;
                  w_count_nxt = '0;
               end else if (r_count == LAST_CNT) begin
                  w_state_nxt = HIGH_STABLE;
                  w_count_nxt = '0;
                  w_out_nxt   = 1'b1;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_count_nxt = r_count + ONE_CNT;
               end
            end
            HIGH_STABLE: begin
               if (!input_i) begin
                  w_state_nxt = FALL_CHECK;
                  w_count_nxt = ONE_CNT;
               end else begin
                  w_count_nxt = '0;
               end
            end
            FALL_CHECK: begin
               if (input_i) begin
                  w_state_nxt = HIGH_STABLE;
                  w_count_nxt = '0;
               end else if (r_count == LAST_CNT) begin
                  w_state_nxt = LOW_STABLE;
                  w_count_nxt = '0;
                  w_out_nxt   = 1'b0;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_count_nxt = r_count + ONE_CNT;
               end
            end
            default: begin
               w_state_nxt = LOW_STABLE;
               w_count_nxt = '0;
            end
         endcase
      end
   end

   assign output_o = r_out;
   assign rise_o   = r_rise;
   assign fall_o   = r_fall;

endmodule
